// File: rtl/switch_led_ctrl_if.sv
// Switch/LED bundle: raw switches and mode in, LED drive, debounced state and change-mask handshake out.
interface switch_led_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] i_switches;
  logic [1:0]       i_mode;
  logic             i_change_ready;
  logic [WIDTH-1:0] o_led;
  logic [WIDTH-1:0] o_sw_stable;
  logic             o_change_valid;
  logic [WIDTH-1:0] o_change_mask;

  modport master (
    output i_switches, i_mode, i_change_ready,
    input  o_led, o_sw_stable, o_change_valid, o_change_mask
  );

  modport slave (
    input  i_switches, i_mode, i_change_ready,
    output o_led, o_sw_stable, o_change_valid, o_change_mask
  );
endinterface

// File: rtl/switch_led_ctrl.sv
// Per-channel switch debouncer with an OR-accumulated change mask (valid/ready) and a
// registered LED driver with mirror, toggle, blink and off modes. Switch->stable: 2+DEBOUNCE_CYCLES.
module switch_led_ctrl #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  switch_led_ctrl_if.slave  bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] stable, stable_d;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] toggle;
  logic [BW-1:0]    blink_cnt;
  logic             blink_phase;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] led;

  logic [WIDTH-1:0] trans, rises, mask_next, led_next;
  logic             valid, hs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= bus.i_switches;
      sync2 <= sync1;
      // Stable bit follows only after CNT_MAX+1 consecutive differing cycles.
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Transitions are seen one cycle after the stable bit moves.
  assign trans     = stable ^ stable_d;
  assign rises     = stable & ~stable_d;
  assign valid     = |mask;
  assign hs        = valid & bus.i_change_ready;
  assign mask_next = hs ? trans : (mask | trans);

  always_comb begin
    led_next = '0;
    case (bus.i_mode)
      2'd0:    led_next = stable;
      2'd1:    led_next = toggle;
      2'd2:    led_next = stable & {WIDTH{blink_phase}};
      default: led_next = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_d    <= '0;
      toggle      <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      mask        <= '0;
      led         <= '0;
    end else begin
      stable_d <= stable;
      toggle   <= toggle ^ rises;
      mask     <= mask_next;
      led      <= led_next;
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign bus.o_led          = led;
  assign bus.o_sw_stable    = stable;
  assign bus.o_change_valid = valid;
  assign bus.o_change_mask  = mask;

endmodule

// File: doc/switch_led_ctrl.md
SWITCH_LED_CTRL -- requirements
Module: switch_led_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of switch/LED channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of consecutive stable clock cycles required to accept a switch change (10 ms at 100 MHz).
REQ-003 The block SHALL have parameter BLINK_DIV, default 25000000, giving the number of clock cycles per blink half-period.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge active.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_switches, input, WIDTH bits: raw asynchronous switch levels.
REQ-007 The block SHALL have port i_mode, input, 2 bits: LED display mode select.
REQ-008 The block SHALL have port i_change_ready, input, 1 bit: the consumer accepts the change mask.
REQ-009 The block SHALL have port o_led, output, WIDTH bits: registered LED drive.
REQ-010 The block SHALL have port o_sw_stable, output, WIDTH bits: the debounced switch state.
REQ-011 The block SHALL have port o_change_valid, output, 1 bit: a change mask is pending.
REQ-012 The block SHALL have port o_change_mask, output, WIDTH bits: the channels whose debounced state changed since the last handshake.

Function
REQ-013 Each i_switches bit SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-014 Each channel SHALL have its own debounce counter sized to count to DEBOUNCE_CYCLES-1.
REQ-015 When a channel's synchronised bit equals its stable bit, that channel's counter SHALL be cleared.
REQ-016 When the synchronised bit differs from the stable bit, the counter SHALL increment each cycle.
REQ-017 When the counter is at DEBOUNCE_CYCLES-1 and the bits still differ, the stable bit SHALL take the synchronised value and the counter SHALL clear in the same cycle.
REQ-018 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave o_sw_stable unchanged.
REQ-019 Latency from a clean edge on i_switches to o_sw_stable SHALL be 2+DEBOUNCE_CYCLES cycles.
REQ-020 The change mask SHALL use OR-accumulation: every stable-bit transition (either direction) SHALL set the corresponding bit of the pending mask.
REQ-021 Two transitions of the same bit before a handshake SHALL leave that mask bit at 1.
REQ-022 o_change_valid SHALL be 1 exactly when the pending mask is non-zero.
REQ-023 o_change_mask SHALL present the pending mask and SHALL never lose a set bit while o_change_valid=1 and i_change_ready=0.
REQ-024 A handshake occurs when o_change_valid=1 and i_change_ready=1; on it the pending mask SHALL be replaced by the transitions occurring in that same cycle (zero if there are none).
REQ-025 When i_change_ready=1 and o_change_valid=0, the block SHALL take no action.
REQ-026 Mode 0 (mirror): o_led SHALL equal o_sw_stable.
REQ-027 Mode 1 (toggle): on each 0->1 transition of stable bit i, internal toggle bit i SHALL invert, and o_led SHALL equal the toggle register.
REQ-028 Mode 2 (blink): o_led SHALL equal o_sw_stable AND a blink phase that inverts every BLINK_DIV cycles from a free-running counter.
REQ-029 Mode 3 (off): o_led SHALL be all zeros.
REQ-030 o_led SHALL be registered, reflecting mode and state one cycle after they change.
REQ-031 The toggle register and blink counter SHALL keep running in every mode, so that a mode change does not clear them.

Reset
REQ-032 Asserting i_rst_n=0 SHALL immediately clear all of the following, regardless of clock:
- synchroniser flops, debounce counters and o_sw_stable
- toggle register, blink counter and blink phase
- pending mask, o_change_valid and o_led
REQ-033 After deassertion, a switch already high SHALL register as a 0->1 transition after 2+DEBOUNCE_CYCLES cycles, setting the mask bit and, in mode 1, the toggle bit.
REQ-034 Reset mid-debounce or with a pending mask SHALL discard all in-progress state.

Verification
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, BLINK_DIV=3.
REQ-035 Debounce: i_switches 0000->0001, held -> o_sw_stable=0001 exactly 6 cycles later; o_change_valid=1 and o_change_mask=0001 one cycle after that.
REQ-036 Glitch: bit1 pulsed high for 3 cycles -> o_sw_stable and o_change_valid stay 0.
REQ-037 Backpressure: with i_change_ready=0, bit0 rises and later falls -> mask stays 0001; ready=1 for one cycle -> o_change_valid=0 next cycle.
REQ-038 Simultaneous events: a handshake in the same cycle bit2 changes -> mask becomes 0100 and valid stays 1.
REQ-039 Modes:
- Mode 1: two press/release cycles on bit3 -> o_led[3] goes 1 then 0.
- Mode 2 with stable=1111: o_led alternates between 1111 and 0000 every 3 cycles.
- Mode 3: o_led=0000.
REQ-040 Reset: assert i_rst_n mid-debounce with the mask pending -> all outputs are 0 immediately, with no clock required.
